// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: drives the VGA timing generator's enable, write strobe
// and timing fields. A mode change waits for vertical blank (or a timeout),
// stops the generator, loads the new timing table, settles, restarts, and
// keeps pixels blanked until the first full frame of the new mode.
//
// Ports:
//   clk_25m, rst                 pixel clock, synchronous active-high reset
//   mode_req_i/_valid_i/_ready_o mode request handshake (ready only in RUN)
//   hcount_i, vcount_i           timing generator position
//   tg_en_o, tg_we_o             timing generator enable / field write strobe
//   hd_o..hb_o, vd_o..vb_o       timing fields (display/front/sync/back)
//   mode_o                       mode currently programmed
//   blank_o                      force pixel output black
//   done_o                       one-cycle pulse when a request completes
module vga_mode_sequencer #(
  parameter int unsigned DEFAULT_MODE  = 0,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned VB_TIMEOUT    = 2000000
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic [1:0]  mode_req_i,
  input  logic        mode_req_valid_i,
  output logic        mode_req_ready_o,
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  output logic        tg_en_o,
  output logic        tg_we_o,
  output logic [10:0] hd_o,
  output logic [10:0] hf_o,
  output logic [10:0] hr_o,
  output logic [10:0] hb_o,
  output logic [9:0]  vd_o,
  output logic [9:0]  vf_o,
  output logic [9:0]  vr_o,
  output logic [9:0]  vb_o,
  output logic [1:0]  mode_o,
  output logic        blank_o,
  output logic        done_o
);

  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TO_W = (VB_TIMEOUT > 1) ? $clog2(VB_TIMEOUT) : 1;
  localparam logic [1:0]      DEF_MODE   = 2'(DEFAULT_MODE);
  localparam logic [SC_W-1:0] SETTLE_MAX = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] VB_MAX     = TO_W'(VB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SETTLE,
    S_WAIT_SOF,
    S_RUN,
    S_WAIT_VB,
    S_STOP
  } state_e;

  typedef struct packed {
    logic [10:0] hd;
    logic [10:0] hf;
    logic [10:0] hr;
    logic [10:0] hb;
    logic [9:0]  vd;
    logic [9:0]  vf;
    logic [9:0]  vr;
    logic [9:0]  vb;
  } timing_t;

  // Timing table lookup
  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    case (m)
      2'd0:    t = '{hd: 11'd640,  hf: 11'd16, hr: 11'd96,  hb: 11'd48,
                     vd: 10'd480,  vf: 10'd10, vr: 10'd2,   vb: 10'd33};
      2'd1:    t = '{hd: 11'd800,  hf: 11'd40, hr: 11'd128, hb: 11'd88,
                     vd: 10'd600,  vf: 10'd1,  vr: 10'd4,   vb: 10'd23};
      2'd2:    t = '{hd: 11'd1024, hf: 11'd24, hr: 11'd136, hb: 11'd160,
                     vd: 10'd768,  vf: 10'd3,  vr: 10'd6,   vb: 10'd29};
      default: t = '{hd: 11'd1366, hf: 11'd70, hr: 11'd143, hb: 11'd213,
                     vd: 10'd768,  vf: 10'd3,  vr: 10'd3,   vb: 10'd24};
    endcase
    return t;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      target_q, target_d;
  logic [1:0]      mode_q, mode_d;
  timing_t         timing_q, timing_d;
  logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0] vb_cnt_q, vb_cnt_d;
  logic            pending_q, pending_d;   // a reprogramming request awaits its done pulse
  logic            tg_en_q, tg_en_d;
  logic            tg_we_q, tg_we_d;
  logic            blank_q, blank_d;
  logic            done_q, done_d;

  // State and output registers
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q      <= S_LOAD;
      target_q     <= DEF_MODE;
      mode_q       <= DEF_MODE;
      timing_q     <= mode_timing(DEF_MODE);
      settle_cnt_q <= '0;
      vb_cnt_q     <= '0;
      pending_q    <= 1'b0;
      tg_en_q      <= 1'b0;
      tg_we_q      <= 1'b0;
      blank_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      mode_q       <= mode_d;
      timing_q     <= timing_d;
      settle_cnt_q <= settle_cnt_d;
      vb_cnt_q     <= vb_cnt_d;
      pending_q    <= pending_d;
      tg_en_q      <= tg_en_d;
      tg_we_q      <= tg_we_d;
      blank_q      <= blank_d;
      done_q       <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    mode_d       = mode_q;
    timing_d     = timing_q;
    settle_cnt_d = settle_cnt_q;
    vb_cnt_d     = vb_cnt_q;
    pending_d    = pending_q;
    tg_we_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      S_LOAD: begin
        timing_d     = mode_timing(target_q);
        mode_d       = target_q;
        tg_we_d      = 1'b1;
        settle_cnt_d = SETTLE_MAX;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_WAIT_SOF;
        end else begin
          settle_cnt_d = settle_cnt_q - SC_W'(1);
        end
      end
      S_WAIT_SOF: begin
        if (hcount_i == '0 && vcount_i == '0) begin
          state_d   = S_RUN;
          done_d    = pending_q;   // silent after reset: no request pending
          pending_d = 1'b0;
        end
      end
      S_RUN: begin
        if (mode_req_valid_i) begin
          target_d = mode_req_i;
          if (mode_req_i == mode_q) begin
            // Back-to-back same-mode accepts must not stretch done into two cycles
            done_d = ~done_q;
          end else begin
            state_d   = S_WAIT_VB;
            vb_cnt_d  = '0;
            pending_d = 1'b1;
          end
        end
      end
      S_WAIT_VB: begin
        if ((vcount_i == timing_q.vd && hcount_i == '0) || vb_cnt_q == VB_MAX) begin
          state_d = S_STOP;
        end else begin
          vb_cnt_d = vb_cnt_q + TO_W'(1);
        end
      end
      S_STOP: begin
        state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Enable and blank follow the state being entered so they are registered
    tg_en_d = (state_d == S_WAIT_SOF) || (state_d == S_RUN) || (state_d == S_WAIT_VB);
    blank_d = !((state_d == S_RUN) || (state_d == S_WAIT_VB));
  end

  assign mode_req_ready_o = (state_q == S_RUN);
  assign tg_en_o          = tg_en_q;
  assign tg_we_o          = tg_we_q;
  assign blank_o          = blank_q;
  assign done_o           = done_q;
  assign mode_o           = mode_q;
  assign hd_o             = timing_q.hd;
  assign hf_o             = timing_q.hf;
  assign hr_o             = timing_q.hr;
  assign hb_o             = timing_q.hb;
  assign vd_o             = timing_q.vd;
  assign vf_o             = timing_q.vf;
  assign vr_o             = timing_q.vr;
  assign vb_o             = timing_q.vb;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer. Expected timing-table loads and
// done pulses are queued as stimulus is driven and consumed by a monitor
// when the DUT strobes tg_we_o or done_o; sequencing is checked inline.
module tb_vga_mode_sequencer;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned VBTO   = 100;

  logic        clk_25m = 1'b0;
  logic        rst;
  logic [1:0]  mode_req_i;
  logic        mode_req_valid_i;
  logic        mode_req_ready_o;
  logic [10:0] hcount_i;
  logic [9:0]  vcount_i;
  logic        tg_en_o, tg_we_o;
  logic [10:0] hd_o, hf_o, hr_o, hb_o;
  logic [9:0]  vd_o, vf_o, vr_o, vb_o;
  logic [1:0]  mode_o;
  logic        blank_o, done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  logic done_prev = 1'b0;

  logic [1:0] exp_load_q[$];
  logic [1:0] exp_done_q[$];

  vga_mode_sequencer #(
    .DEFAULT_MODE (0),
    .SETTLE_CYCLES(SETTLE),
    .VB_TIMEOUT   (VBTO)
  ) dut (
    .clk_25m         (clk_25m),
    .rst             (rst),
    .mode_req_i      (mode_req_i),
    .mode_req_valid_i(mode_req_valid_i),
    .mode_req_ready_o(mode_req_ready_o),
    .hcount_i        (hcount_i),
    .vcount_i        (vcount_i),
    .tg_en_o         (tg_en_o),
    .tg_we_o         (tg_we_o),
    .hd_o            (hd_o),
    .hf_o            (hf_o),
    .hr_o            (hr_o),
    .hb_o            (hb_o),
    .vd_o            (vd_o),
    .vf_o            (vf_o),
    .vr_o            (vr_o),
    .vb_o            (vb_o),
    .mode_o          (mode_o),
    .blank_o         (blank_o),
    .done_o          (done_o)
  );

  always #5 clk_25m = ~clk_25m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference timing table {hd,hf,hr,hb,vd,vf,vr,vb}
  function automatic logic [83:0] ref_fields(input logic [1:0] m);
    case (m)
      2'd0:    return {11'd640,  11'd16, 11'd96,  11'd48,  10'd480, 10'd10, 10'd2, 10'd33};
      2'd1:    return {11'd800,  11'd40, 11'd128, 11'd88,  10'd600, 10'd1,  10'd4, 10'd23};
      2'd2:    return {11'd1024, 11'd24, 11'd136, 11'd160, 10'd768, 10'd3,  10'd6, 10'd29};
      default: return {11'd1366, 11'd70, 11'd143, 11'd213, 10'd768, 10'd3,  10'd3, 10'd24};
    endcase
  endfunction

  // Monitor: consume scoreboard entries on load strobes and done pulses
  always @(negedge clk_25m) begin
    logic [1:0]  m;
    logic [83:0] f;
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      if (mode_req_valid_i && mode_req_ready_o) acc_cnt++;
      if (tg_we_o) begin
        if (exp_load_q.size() == 0) begin
          check_eq("load_unexpected", 64'(1), 64'(0));
        end else begin
          m = exp_load_q.pop_front();
          f = ref_fields(m);
          check_eq("load_mode", 64'(mode_o), 64'(m));
          check_eq("load_hfields", 64'({hd_o, hf_o, hr_o, hb_o}), 64'(f[83:40]));
          check_eq("load_vfields", 64'({vd_o, vf_o, vr_o, vb_o}), 64'(f[39:0]));
        end
      end
      if (done_o) begin
        check_eq("done_consecutive", 64'(done_prev), 64'(0));
        if (exp_done_q.size() == 0) begin
          check_eq("done_unexpected", 64'(1), 64'(0));
        end else begin
          m = exp_done_q.pop_front();
          check_eq("done_mode", 64'(mode_o), 64'(m));
        end
      end
      done_prev <= done_o;
    end
  end

  task automatic cyc();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic wait_en(input logic val, input string tag, output int n);
    n = 0;
    while (tg_en_o !== val && n < 300) begin
      cyc();
      n++;
    end
    if (tg_en_o !== val) check_eq({tag, "_timeout"}, 64'(tg_en_o), 64'(val));
  endtask

  task automatic wait_we(input string tag);
    int n = 0;
    while (tg_we_o !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    if (tg_we_o !== 1'b1) check_eq({tag, "_timeout"}, 64'(tg_we_o), 64'(1));
  endtask

  // Bring the generator up, present a frame start and check the done pulse
  task automatic finish_switch(input logic exp_done, input string tag);
    int n;
    wait_en(1'b1, {tag, "_en"}, n);
    cyc();
    cyc();
    check_eq({tag, "_sof_blank"}, 64'(blank_o), 64'(1));
    hcount_i = 11'd0;
    vcount_i = 10'd0;
    cyc();
    check_eq({tag, "_done"}, 64'(done_o), 64'(exp_done));
    check_eq({tag, "_unblank"}, 64'(blank_o), 64'(0));
    check_eq({tag, "_ready"}, 64'(mode_req_ready_o), 64'(1));
    hcount_i = 11'd5;
    vcount_i = 10'd5;
    cyc();
    check_eq({tag, "_done_off"}, 64'(done_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int ready_hi;
    logic [3:0] dpat;

    rst = 1'b1;
    mode_req_i = 2'd0;
    mode_req_valid_i = 1'b0;
    hcount_i = 11'd5;
    vcount_i = 10'd5;
    repeat (3) cyc();

    // Reset state
    check_eq("rst_en", 64'(tg_en_o), 64'(0));
    check_eq("rst_we", 64'(tg_we_o), 64'(0));
    check_eq("rst_blank", 64'(blank_o), 64'(1));
    check_eq("rst_ready", 64'(mode_req_ready_o), 64'(0));
    check_eq("rst_done", 64'(done_o), 64'(0));
    check_eq("rst_mode", 64'(mode_o), 64'(0));
    check_eq("rst_hd", 64'(hd_o), 64'(640));
    check_eq("rst_vb", 64'(vb_o), 64'(33));

    // Power-up sequence
    exp_load_q.push_back(2'd0);
    rst = 1'b0;
    cyc();
    check_eq("pu_we", 64'(tg_we_o), 64'(1));
    check_eq("pu_hd", 64'(hd_o), 64'(640));
    cyc();
    check_eq("pu_we_pulse", 64'(tg_we_o), 64'(0));
    wait_en(1'b1, "pu_en", n);
    check_eq("pu_settle_len", 64'(n + 1), 64'(SETTLE));
    finish_switch(1'b0, "pu");

    // Same-mode request: no reprogramming, done one cycle after accept
    mode_req_i = 2'd0;
    mode_req_valid_i = 1'b1;
    exp_done_q.push_back(2'd0);
    cyc();
    mode_req_valid_i = 1'b0;
    check_eq("same_done", 64'(done_o), 64'(1));
    check_eq("same_en", 64'(tg_en_o), 64'(1));
    check_eq("same_we", 64'(tg_we_o), 64'(0));
    cyc();
    check_eq("same_done_off", 64'(done_o), 64'(0));
    check_eq("same_ready", 64'(mode_req_ready_o), 64'(1));

    // Switch 0 -> 2 through vertical blank
    mode_req_i = 2'd2;
    mode_req_valid_i = 1'b1;
    vcount_i = 10'd100;
    hcount_i = 11'd3;
    exp_load_q.push_back(2'd2);
    exp_done_q.push_back(2'd2);
    cyc();
    mode_req_valid_i = 1'b0;
    check_eq("m2_ready_drop", 64'(mode_req_ready_o), 64'(0));
    check_eq("m2_blank_vb", 64'(blank_o), 64'(0));
    repeat (5) cyc();
    check_eq("m2_en_hold", 64'(tg_en_o), 64'(1));
    vcount_i = 10'd480;
    hcount_i = 11'd0;
    cyc();
    check_eq("m2_stop_en", 64'(tg_en_o), 64'(0));
    check_eq("m2_stop_blank", 64'(blank_o), 64'(1));
    hcount_i = 11'd5;
    vcount_i = 10'd5;
    wait_we("m2_we");
    check_eq("m2_hd", 64'(hd_o), 64'(1024));
    check_eq("m2_vd", 64'(vd_o), 64'(768));
    check_eq("m2_mode", 64'(mode_o), 64'(2));
    finish_switch(1'b1, "m2");

    // Switch 2 -> 3 forced by the vertical-blank timeout
    mode_req_i = 2'd3;
    mode_req_valid_i = 1'b1;
    hcount_i = 11'd7;
    vcount_i = 10'd5;
    exp_load_q.push_back(2'd3);
    exp_done_q.push_back(2'd3);
    cyc();
    mode_req_valid_i = 1'b0;
    wait_en(1'b0, "m3_stop", n);
    check_eq("m3_timeout_len", 64'(n), 64'(VBTO));
    hcount_i = 11'd5;
    wait_we("m3_we");
    check_eq("m3_hb", 64'(hb_o), 64'(213));
    check_eq("m3_vr", 64'(vr_o), 64'(3));
    finish_switch(1'b1, "m3");

    // Switch 3 -> 1 interrupted by reset during SETTLE
    mode_req_i = 2'd1;
    mode_req_valid_i = 1'b1;
    exp_load_q.push_back(2'd1);
    cyc();
    mode_req_valid_i = 1'b0;
    vcount_i = 10'd768;
    hcount_i = 11'd0;
    cyc();
    check_eq("m1_stop_en", 64'(tg_en_o), 64'(0));
    hcount_i = 11'd5;
    vcount_i = 10'd5;
    wait_we("m1_we");
    repeat (3) cyc();
    rst = 1'b1;
    exp_load_q.push_back(2'd0);
    cyc();
    rst = 1'b0;
    check_eq("mrst_mode", 64'(mode_o), 64'(0));
    check_eq("mrst_hd", 64'(hd_o), 64'(640));
    check_eq("mrst_en", 64'(tg_en_o), 64'(0));
    cyc();
    check_eq("mrst_reload_we", 64'(tg_we_o), 64'(1));
    finish_switch(1'b0, "mrst");

    // Valid held through a whole 0 -> 2 switch: a single accept
    base = acc_cnt;
    ready_hi = 0;
    mode_req_i = 2'd2;
    mode_req_valid_i = 1'b1;
    exp_load_q.push_back(2'd2);
    exp_done_q.push_back(2'd2);
    cyc();
    repeat (4) begin
      cyc();
      if (mode_req_ready_o) ready_hi++;
    end
    vcount_i = 10'd480;
    hcount_i = 11'd0;
    cyc();
    if (mode_req_ready_o) ready_hi++;
    vcount_i = 10'd5;
    hcount_i = 11'd5;
    n = 0;
    while (!(tg_en_o && blank_o) && n < 60) begin
      cyc();
      if (mode_req_ready_o) ready_hi++;
      n++;
    end
    check_eq("hold_reach_sof", 64'(tg_en_o && blank_o), 64'(1));
    hcount_i = 11'd0;
    vcount_i = 10'd0;
    mode_req_valid_i = 1'b0;
    cyc();
    hcount_i = 11'd5;
    vcount_i = 10'd5;
    check_eq("hold_ready_blocked", 64'(ready_hi), 64'(0));
    check_eq("hold_accepts", 64'(acc_cnt - base), 64'(1));
    check_eq("hold_done", 64'(done_o), 64'(1));
    check_eq("hold_mode", 64'(mode_o), 64'(2));

    // Valid held on the current mode: one accept per cycle, done never back-to-back
    cyc();
    base = acc_cnt;
    mode_req_valid_i = 1'b1;
    exp_done_q.push_back(2'd2);
    exp_done_q.push_back(2'd2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      dpat[i] = done_o;
    end
    mode_req_valid_i = 1'b0;
    cyc();
    check_eq("rep_accepts", 64'(acc_cnt - base), 64'(4));
    check_eq("rep_done_pattern", 64'(dpat), 64'(4'b0101));
    check_eq("rep_we", 64'(tg_we_o), 64'(0));

    cyc();
    check_eq("sb_load_empty", 64'(exp_load_q.size()), 64'(0));
    check_eq("sb_done_empty", 64'(exp_done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
- Controls the VGA timing generator: owns its enable, write-enable and the eight timing-field inputs.
- Performs glitch-free video mode changes on request:
  - waits for vertical blank;
  - stops the timing generator;
  - loads the new mode's timing table;
  - settles;
  - restarts;
  - holds pixel output blanked until the first full new frame begins.
- Sits between the mode-select CSR logic and the timing generator in the VGA block.

Parameters:
- DEFAULT_MODE, 0, mode loaded after reset (0=640x480, 1=800x600, 2=1024x768, 3=1366x768).
- SETTLE_CYCLES, 16, cycles held in SETTLE after the load, before re-enable (≥1).
- VB_TIMEOUT, 2000000, cycles to wait for vertical blank before forcing the switch.

Ports:
- clk_25m  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_req_i  in  2  requested mode.
- mode_req_valid_i  in  1  request valid.
- mode_req_ready_o  out  1  request accepted when valid&ready.
- hcount_i  in  11  timing generator horizontal count.
- vcount_i  in  10  timing generator vertical count.
- tg_en_o  out  1  timing generator enable.
- tg_we_o  out  1  one-cycle timing-field write strobe.
- hd_o, hf_o, hr_o, hb_o  out  11 each  horizontal display/front porch/sync/back porch.
- vd_o, vf_o, vr_o, vb_o  out  10 each  vertical display/front porch/sync/back porch.
- mode_o  out  2  mode currently programmed.
- blank_o  out  1  force pixel output black.
- done_o  out  1  one-cycle pulse when a request completes.

Behaviour:
- Timing table, per mode as (hd,hf,hr,hb / vd,vf,vr,vb):
  - mode 0: 640,16,96,48 / 480,10,2,33
  - mode 1: 800,40,128,88 / 600,1,4,23
  - mode 2: 1024,24,136,160 / 768,3,6,29
  - mode 3: 1366,70,143,213 / 768,3,3,24
- Timing-field outputs are registers. They change only in LOAD and are stable in every other state.
- States: LOAD, SETTLE, WAIT_SOF, RUN, WAIT_VB, STOP.
- Reset: state=LOAD, target=DEFAULT_MODE, tg_en_o=0, tg_we_o=0, blank_o=1, mode_req_ready_o=0, done_o=0, mode_o=DEFAULT_MODE, field outputs = table[DEFAULT_MODE].
- Reset mid-sequence abandons any pending request; a held request must be re-presented.
- LOAD (1 cycle):
  - fields <= table[target]; mode_o <= target; tg_we_o=1 this cycle only; tg_en_o=0.
  - -> SETTLE, counter <= SETTLE_CYCLES-1.
- SETTLE: tg_en_o=0; count down; at 0 -> WAIT_SOF with tg_en_o=1 from the next cycle.
- WAIT_SOF:
  - tg_en_o=1, blank_o=1.
  - On the first cycle with hcount_i==0 && vcount_i==0 -> RUN; blank_o=0 from the next cycle.
  - done_o pulses in the transition cycle, except after reset, where done_o stays 0.
- RUN:
  - tg_en_o=1, blank_o=0, mode_req_ready_o=1. Ready is combinationally (state==RUN).
  - On accept: target <= mode_req_i.
    - If mode_req_i==mode_o: no reprogramming, stay in RUN, done_o pulses the next cycle.
    - Otherwise -> WAIT_VB, timeout counter cleared.
- WAIT_VB:
  - tg_en_o=1, blank_o=0.
  - -> STOP when vcount_i==vd_o && hcount_i==0 (first line of vertical front porch, current mode).
  - -> STOP when the timeout counter reaches VB_TIMEOUT-1; the timeout counter saturates and does not wrap.
- STOP (1 cycle): tg_en_o=0, blank_o=1; -> LOAD.
- blank_o is 1 in every state except RUN and WAIT_VB.
- Requests are never accepted outside RUN; mode_req_valid_i is ignored there.
- done_o is never high in two consecutive cycles.
- Inputs hcount_i/vcount_i are used only in WAIT_VB and WAIT_SOF.

Test Plan:
- Reset, DEFAULT_MODE=0 -> tg_we_o high exactly 1 cycle after reset release with hd_o=640, vb_o=33. tg_en_o rises after 16 SETTLE cycles. blank_o falls the cycle after the stimulus drives hcount=0 and vcount=0. done_o stays 0.
- In RUN, request mode 2 while vcount_i=100 -> ready drops. tg_en_o stays 1 until the stimulus reaches vcount_i=480 and hcount_i=0. Then STOP, then LOAD with hd_o=1024, vd_o=768, mode_o=2. done_o pulses at the next frame start.
- Request mode 0 while mode_o=0 -> tg_we_o never asserts, tg_en_o stays 1, done_o pulses exactly 1 cycle after the accept.
- Request mode 3 with vcount_i frozen at 5 and VB_TIMEOUT=100 -> STOP is forced at 100 cycles. hb_o=213 and vr_o=3 after LOAD.
- Assert rst for 1 cycle while in SETTLE during a switch to mode 1 -> the sequence restarts at LOAD with DEFAULT_MODE fields. The mode-1 request is lost and done_o stays 0.
- Hold valid through a whole switch -> exactly one accept per RUN-state cycle with ready=1. No request is accepted in WAIT_VB, STOP, LOAD, SETTLE or WAIT_SOF.
